apex_meta_ctrl: RTL and testbench
=================================

Name: apex_meta_ctrl

Overview:
- Memory-mapped configuration and sequencing controller for the APEX proof-of-execution datapath.
- Holds ER_min/ER_max/OR_min/OR_max in a register bank at META_BASE and drives them into hwmod.
- Locks that configuration while an execution is armed or running.
- Tracks each attempt through arm, run, done or fail using pc and hwmod's exec output; exposes status to software.

Parameters:
- META_BASE, 16'h0140, byte address of register bank (6 words, offsets 0x0–0xA)
- ER_RST, 16'hE000, reset value of ER_min and ER_max
- OR_RST, 16'hF000, reset value of OR_min and OR_max

Ports:
- clk  in  1  system clock
- puc  in  1  asynchronous active-high reset
- pc  in  16  CPU program counter
- data_en  in  1  CPU data access strobe
- data_wr  in  1  CPU write qualifier
- data_addr  in  16  CPU byte address
- data_wdata  in  16  CPU write data
- data_rdata  out  16  read data, registered
- dma_en  in  1  DMA access strobe
- dma_addr  in  16  DMA byte address
- exec  in  1  hwmod exec flag
- er_min, er_max, or_min, or_max  out  16 each  to hwmod
- locked  out  1  config write-protected
- done  out  1  attempt completed with exec high
- fail  out  1  attempt aborted

Behaviour:
- Register map (word offsets from META_BASE):
  - 0x0 ER_MIN, 0x2 ER_MAX, 0x4 OR_MIN, 0x6 OR_MAX: read/write
  - 0x8 CTRL: write-only; bit0 ARM, bit1 CLEAR; reads 0
  - 0xA STATUS: read-only; {10'b0, cfg_err, dma_viol, state[2:0], exec}
- Decode on data_addr[15:1]; data_addr[0] ignored. Full 16-bit accesses only.
- Write strobe = data_en & data_wr & hit. Read data is valid on the cycle after data_en & ~data_wr & hit. Otherwise data_rdata = 0.
- Reset (puc async):
  - state = IDLE
  - er_min = er_max = ER_RST; or_min = or_max = OR_RST
  - locked = done = fail = 0
  - cfg_err = dma_viol = 0; data_rdata = 0
- State encoding: IDLE=0, ARMED=1, RUN=2, DONE=3, FAIL=4.
- IDLE:
  - Bound registers are writable.
  - ARM write moves to ARMED next cycle, but only if er_min < er_max, or_min <= or_max, and er_min[0] = er_max[0] = 0.
  - If the ARM check fails: stay in IDLE and set cfg_err (sticky).
- ARMED:
  - locked = 1; bound writes are silently dropped.
  - pc == er_min and exec == 1 → RUN.
  - exec falling 1→0 → FAIL.
- RUN:
  - pc == er_max and exec == 1 → DONE.
  - exec == 0 → FAIL.
  - pc leaving the ER while exec stays high is not checked here; vape enforces it.
- DONE: done = 1, locked = 1. Leaves to IDLE only on a CLEAR write.
- FAIL: fail = 1, locked = 0. Leaves to IDLE only on a CLEAR write.
- CLEAR:
  - In ARMED or RUN: → FAIL.
  - In DONE or FAIL: → IDLE; clears cfg_err and dma_viol.
  - In IDLE: clears cfg_err and dma_viol only.
- ARM and CLEAR written together: CLEAR wins.
- done, fail and locked are registered decodes of state (1-cycle after the state change).
- DMA protection: dma_en with dma_addr inside [META_BASE, META_BASE+0xB] sets dma_viol (sticky) in every state. If in ARMED or RUN, also → FAIL the next cycle.
- Simultaneous events in the same cycle (evaluated in ARMED/RUN): CLEAR/DMA fail > exec-drop fail > progress transition.
- A CPU write to a bound register in the same cycle as an accepted ARM takes effect; the ARM check uses the pre-write values.

Test Plan:
- Reset, then read 0x0140 → 16'hE000. Write ER_MIN=E100, ER_MAX=E200, then ARM with exec=1 → STATUS.state=1, locked=1 next cycle.
- From ARMED: pc=E100 → RUN. pc=E200 with exec high → DONE, done=1. Write ER_MIN=0 → readback stays E100. CLEAR → IDLE, locked=0.
- ARM with ER_MIN=E200, ER_MAX=E100 → state stays 0, cfg_err=1, locked=0.
- RUN, then drop exec → FAIL, fail=1, locked=0. CLEAR → IDLE, fail=0.
- ARMED with dma_en=1, dma_addr=0x0144 → FAIL, dma_viol=1. Repeat in IDLE → dma_viol=1, state=0.
- Assert puc asynchronously mid-RUN → all outputs return to reset values immediately; bounds = E000/E000/F000/F000.

Source files
------------

// File: rtl/apex_meta_ctrl.sv
// APEX metadata controller: holds the ER/OR bound registers, write-protects them
// while an attempt is in flight, and sequences each attempt through arm/run/done/fail.
module apex_meta_ctrl #(
    parameter logic [15:0] META_BASE = 16'h0140,
    parameter logic [15:0] ER_RST    = 16'hE000,
    parameter logic [15:0] OR_RST    = 16'hF000
) (
    input  logic        clk,
    input  logic        puc,
    input  logic [15:0] pc,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic [15:0] data_rdata,
    input  logic        dma_en,
    input  logic [15:0] dma_addr,
    input  logic        exec,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic [15:0] or_min,
    output logic [15:0] or_max,
    output logic        locked,
    output logic        done,
    output logic        fail
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } state_e;

    localparam logic [14:0] BASE_W   = META_BASE[15:1];
    localparam logic [15:0] DMA_LAST = META_BASE + 16'h000B;

    state_e      state_q, state_d;
    logic [15:0] er_min_q, er_min_d, er_max_q, er_max_d;
    logic [15:0] or_min_q, or_min_d, or_max_q, or_max_d;
    logic        cfg_err_q, cfg_err_d, dma_viol_q, dma_viol_d;
    logic        exec_prev_q, exec_prev_d;
    logic        locked_q, locked_d, done_q, done_d, fail_q, fail_d;
    logic [15:0] rdata_q, rdata_d;

    logic [14:0] word_off;
    logic [2:0]  off;
    logic        hit, wr_stb, rd_stb, ctrl_wr, arm_req, clr_req;
    logic        dma_hit, cfg_ok, active, settled, bnd_we;
    logic        unused_addr0;

    // Byte bit 0 is ignored; only whole-word accesses exist.
    assign unused_addr0 = data_addr[0];

    // Addresses below the bank wrap to a large offset, so one compare covers both ends.
    assign word_off = data_addr[15:1] - BASE_W;
    assign hit      = word_off < 15'd6;
    assign off      = word_off[2:0];
    assign wr_stb   = data_en & data_wr & hit;
    assign rd_stb   = data_en & ~data_wr & hit;
    assign ctrl_wr  = wr_stb & (off == 3'd4);
    assign clr_req  = ctrl_wr & data_wdata[1];
    assign arm_req  = ctrl_wr & data_wdata[0] & ~data_wdata[1];
    assign dma_hit  = dma_en & (dma_addr >= META_BASE) & (dma_addr <= DMA_LAST);

    assign cfg_ok   = (er_min_q < er_max_q) && (or_min_q <= or_max_q) &&
                      !er_min_q[0] && !er_max_q[0];
    assign active   = (state_q == ARMED) || (state_q == RUN);
    assign settled  = (state_q == IDLE) || (state_q == DONE) || (state_q == FAIL);
    assign bnd_we   = wr_stb && (off < 3'd4) && ((state_q == IDLE) || (state_q == FAIL));

    // State register
    always_ff @(posedge clk or posedge puc) begin
        if (puc) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: abort (CLEAR/DMA) beats exec loss, which beats forward progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arm_req && cfg_ok) state_d = ARMED;
            end
            ARMED: begin
                if (clr_req || dma_hit)           state_d = FAIL;
                else if (exec_prev_q && !exec)    state_d = FAIL;
                else if (exec && pc == er_min_q)  state_d = RUN;
            end
            RUN: begin
                if (clr_req || dma_hit)           state_d = FAIL;
                else if (!exec)                   state_d = FAIL;
                else if (pc == er_max_q)          state_d = DONE;
            end
            DONE, FAIL: begin
                if (clr_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are decoded from the current state and registered.
    always_comb begin
        locked_d = (state_q == ARMED) || (state_q == RUN) || (state_q == DONE);
        done_d   = (state_q == DONE);
        fail_d   = (state_q == FAIL);
    end

    // Bound bank, sticky flags and read mux
    always_comb begin
        er_min_d    = er_min_q;
        er_max_d    = er_max_q;
        or_min_d    = or_min_q;
        or_max_d    = or_max_q;
        cfg_err_d   = cfg_err_q;
        dma_viol_d  = dma_viol_q;
        exec_prev_d = exec;
        rdata_d     = 16'h0000;

        if (bnd_we) begin
            case (off)
                3'd0:    er_min_d = data_wdata;
                3'd1:    er_max_d = data_wdata;
                3'd2:    or_min_d = data_wdata;
                default: or_max_d = data_wdata;
            endcase
        end

        if (clr_req && settled) begin
            cfg_err_d  = 1'b0;
            dma_viol_d = 1'b0;
        end
        if (arm_req && state_q == IDLE && !cfg_ok) cfg_err_d = 1'b1;
        if (dma_hit) dma_viol_d = 1'b1;

        if (rd_stb) begin
            case (off)
                3'd0:    rdata_d = er_min_q;
                3'd1:    rdata_d = er_max_q;
                3'd2:    rdata_d = or_min_q;
                3'd3:    rdata_d = or_max_q;
                3'd5:    rdata_d = {10'b0, cfg_err_q, dma_viol_q, state_q, exec};
                default: rdata_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge puc) begin
        if (puc) begin
            er_min_q    <= ER_RST;
            er_max_q    <= ER_RST;
            or_min_q    <= OR_RST;
            or_max_q    <= OR_RST;
            cfg_err_q   <= 1'b0;
            dma_viol_q  <= 1'b0;
            exec_prev_q <= 1'b0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            rdata_q     <= 16'h0000;
        end else begin
            er_min_q    <= er_min_d;
            er_max_q    <= er_max_d;
            or_min_q    <= or_min_d;
            or_max_q    <= or_max_d;
            cfg_err_q   <= cfg_err_d;
            dma_viol_q  <= dma_viol_d;
            exec_prev_q <= exec_prev_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            rdata_q     <= rdata_d;
        end
    end

    assign er_min     = er_min_q;
    assign er_max     = er_max_q;
    assign or_min     = or_min_q;
    assign or_max     = or_max_q;
    assign locked     = locked_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign data_rdata = rdata_q;

endmodule

// File: tb/tb_apex_meta_ctrl.sv
// Bench for apex_meta_ctrl: directed vector table, async-reset sequence and
// randomized traffic scored against a behavioural model.
module tb_apex_meta_ctrl;

    logic        clk = 1'b0;
    logic        puc = 1'b1;
    logic [15:0] pc = '0, data_addr = '0, data_wdata = '0, dma_addr = '0;
    logic        data_en = 1'b0, data_wr = 1'b0, dma_en = 1'b0, exec = 1'b0;
    logic [15:0] data_rdata, er_min, er_max, or_min, or_max;
    logic        locked, done, fail;

    int nvec = 0;
    int nerr = 0;

    apex_meta_ctrl dut (
        .clk(clk), .puc(puc), .pc(pc),
        .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .dma_en(dma_en), .dma_addr(dma_addr), .exec(exec),
        .er_min(er_min), .er_max(er_max), .or_min(or_min), .or_max(or_max),
        .locked(locked), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en, wr;
        logic [15:0] addr, wd, pc;
        bit          ex, dma;
        logic [15:0] dadr;
        logic [15:0] rd;
        bit          lk, dn, fl;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit en, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] p, input bit ex, input bit dma, input logic [15:0] dadr,
                       input logic [15:0] rd, input bit lk, input bit dn, input bit fl);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = addr; v.wd = wd; v.pc = p; v.ex = ex;
        v.dma = dma; v.dadr = dadr; v.rd = rd; v.lk = lk; v.dn = dn; v.fl = fl;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit en, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] p, input bit ex, input bit dma, input logic [15:0] dadr);
        data_en = en; data_wr = wr; data_addr = addr; data_wdata = wd;
        pc = p; exec = ex; dma_en = dma; dma_addr = dadr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    localparam int S_IDLE = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3, S_FAIL = 4;
    int          ms, ns;
    logic [15:0] mb[4], nb[4];
    bit          mcfg, mdma, mprev, mlock, mdone, mfail;
    bit          ncfg, ndma, nprev, nlock, ndone, nfail;
    logic [15:0] mrd, nrd;

    task automatic model_reset();
        ms = S_IDLE; mb[0] = 16'hE000; mb[1] = 16'hE000; mb[2] = 16'hF000; mb[3] = 16'hF000;
        mcfg = 0; mdma = 0; mprev = 0; mlock = 0; mdone = 0; mfail = 0; mrd = 16'h0;
    endtask

    task automatic model_eval();
        int  a, idx;
        bit  hit, wr, rd, arm, clr, dmah, act, ok, quiet;
        a    = int'(data_addr) & ~1;
        hit  = (a >= 'h140) && (a < 'h14C);
        idx  = (a - 'h140) / 2;
        wr   = data_en && data_wr && hit;
        rd   = data_en && !data_wr && hit;
        clr  = wr && idx == 4 && data_wdata[1];
        arm  = wr && idx == 4 && data_wdata[0] && !clr;
        dmah = dma_en && int'(dma_addr) >= 'h140 && int'(dma_addr) <= 'h14B;
        act  = (ms == S_ARMED || ms == S_RUN);
        quiet = !act;
        ok   = (mb[0] < mb[1]) && (mb[2] <= mb[3]) && (mb[0] % 2 == 0) && (mb[1] % 2 == 0);

        ns = ms;
        if (act && (clr || dmah))                      ns = S_FAIL;
        else if (ms == S_ARMED && mprev && !exec)      ns = S_FAIL;
        else if (ms == S_RUN && !exec)                 ns = S_FAIL;
        else if (ms == S_ARMED && exec && pc == mb[0]) ns = S_RUN;
        else if (ms == S_RUN && pc == mb[1])           ns = S_DONE;
        else if (ms == S_IDLE && arm && ok)            ns = S_ARMED;
        else if ((ms == S_DONE || ms == S_FAIL) && clr) ns = S_IDLE;

        nb = mb;
        if (wr && idx < 4 && (ms == S_IDLE || ms == S_FAIL)) nb[idx] = data_wdata;

        ncfg = mcfg; ndma = mdma;
        if (clr && quiet) begin ncfg = 0; ndma = 0; end
        if (arm && ms == S_IDLE && !ok) ncfg = 1;
        if (dmah) ndma = 1;

        nrd = 16'h0;
        if (rd) begin
            if (idx < 4)       nrd = mb[idx];
            else if (idx == 5) nrd = 16'(mcfg) << 5 | 16'(mdma) << 4 | 16'(ms) << 1 | 16'(exec);
        end
        nprev = exec;
        nlock = (ms == S_ARMED || ms == S_RUN || ms == S_DONE);
        ndone = (ms == S_DONE);
        nfail = (ms == S_FAIL);
    endtask

    task automatic model_commit();
        ms = ns; mb = nb; mcfg = ncfg; mdma = ndma; mprev = nprev;
        mlock = nlock; mdone = ndone; mfail = nfail; mrd = nrd;
    endtask

    localparam logic [15:0] A_ERMIN = 16'h0140, A_ERMAX = 16'h0142, A_ORMAX = 16'h0146;
    localparam logic [15:0] A_CTRL  = 16'h0148, A_STAT  = 16'h014A;

    initial begin
        // en wr addr wd pc ex dma dadr | rdata lk dn fl
        add(1,0,A_ERMIN,0,0,0,0,0,        16'hE000,0,0,0); // 0 reset readback
        add(1,1,A_ERMIN,16'hE100,0,0,0,0, 16'h0000,0,0,0);
        add(1,1,A_ERMAX,16'hE200,0,0,0,0, 16'h0000,0,0,0);
        add(1,1,A_CTRL,1,0,1,0,0,         16'h0000,0,0,0); // ARM
        add(1,0,A_STAT,0,0,1,0,0,         16'h0003,1,0,0); // armed, exec
        add(0,0,0,0,16'hE100,1,0,0,       16'h0000,1,0,0); // -> RUN
        add(1,0,A_STAT,0,16'hE150,1,0,0,  16'h0005,1,0,0);
        add(0,0,0,0,16'hE200,1,0,0,       16'h0000,1,0,0); // -> DONE
        add(1,1,A_ERMIN,0,0,1,0,0,        16'h0000,1,1,0); // dropped write
        add(1,0,A_ERMIN,0,0,1,0,0,        16'hE100,1,1,0);
        add(1,1,A_CTRL,2,0,0,0,0,         16'h0000,1,1,0); // CLEAR
        add(1,0,A_STAT,0,0,0,0,0,         16'h0000,0,0,0);
        add(1,1,A_ERMIN,16'hE200,0,0,0,0, 16'h0000,0,0,0); // 12 inverted ER
        add(1,1,A_ERMAX,16'hE100,0,0,0,0, 16'h0000,0,0,0);
        add(1,1,A_CTRL,1,0,1,0,0,         16'h0000,0,0,0);
        add(1,0,A_STAT,0,0,0,0,0,         16'h0020,0,0,0); // cfg_err, idle
        add(1,1,A_CTRL,2,0,0,0,0,         16'h0000,0,0,0);
        add(1,0,A_STAT,0,0,0,0,0,         16'h0000,0,0,0);
        add(1,1,A_ERMIN,16'hE100,0,0,0,0, 16'h0000,0,0,0); // 18 exec drop
        add(1,1,A_ERMAX,16'hE200,0,0,0,0, 16'h0000,0,0,0);
        add(1,1,A_CTRL,1,0,1,0,0,         16'h0000,0,0,0);
        add(0,0,0,0,16'hE100,1,0,0,       16'h0000,1,0,0);
        add(0,0,0,0,16'hE102,1,0,0,       16'h0000,1,0,0);
        add(0,0,0,0,16'hE104,0,0,0,       16'h0000,1,0,0); // -> FAIL
        add(1,0,A_STAT,0,0,0,0,0,         16'h0008,0,0,1);
        add(1,1,A_CTRL,2,0,0,0,0,         16'h0000,0,0,1);
        add(0,0,0,0,0,0,0,0,              16'h0000,0,0,0);
        add(1,1,A_CTRL,1,0,1,0,0,         16'h0000,0,0,0); // 27 DMA in ARMED
        add(0,0,0,0,0,1,1,16'h0144,       16'h0000,1,0,0);
        add(1,0,A_STAT,0,0,1,0,0,         16'h0019,0,0,1);
        add(1,1,A_CTRL,2,0,0,0,0,         16'h0000,0,0,1);
        add(0,0,0,0,0,0,1,16'h014B,       16'h0000,0,0,0); // top of window
        add(1,0,A_STAT,0,0,0,0,0,         16'h0010,0,0,0);
        add(1,1,A_CTRL,2,0,0,1,16'h014C,  16'h0000,0,0,0); // outside, clear
        add(1,0,A_STAT,0,0,0,0,0,         16'h0000,0,0,0);
        add(0,0,0,0,0,0,1,16'h013F,       16'h0000,0,0,0); // below window
        add(1,0,A_STAT,0,0,0,0,0,         16'h0000,0,0,0);
        add(1,0,A_CTRL,0,0,0,0,0,         16'h0000,0,0,0); // CTRL reads 0
        add(1,0,16'h0143,0,0,0,0,0,       16'hE200,0,0,0); // odd byte addr
        add(1,0,A_ORMAX,0,0,0,0,0,        16'hF000,0,0,0);

        repeat (2) @(posedge clk);
        #1 puc = 1'b0;
        #1;
        chk("reset_state", {data_rdata, er_min, er_max, or_min, locked, done, fail},
            {16'h0, 16'hE000, 16'hE000, 16'hF000, 3'b000});
        chk("reset_ormax", 64'(or_max), 64'(16'hF000));

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].pc, tbl[i].ex,
                  tbl[i].dma, tbl[i].dadr);
            tick();
            chk($sformatf("vec%0d", i), {data_rdata, locked, done, fail},
                {tbl[i].rd, tbl[i].lk, tbl[i].dn, tbl[i].fl});
        end

        // Async reset while RUN
        drive(1,1,A_CTRL,1,0,1,0,0);        tick();
        drive(0,0,0,0,16'hE100,1,0,0);      tick();
        drive(0,0,0,0,16'hE104,1,0,0);      tick();
        chk("run_locked", 64'(locked), 64'(1));
        #2 puc = 1'b1;
        #1;
        chk("async_reset", {data_rdata, er_min, er_max, or_min, locked, done, fail},
            {16'h0, 16'hE000, 16'hE000, 16'hF000, 3'b000});
        chk("async_reset_ormax", 64'(or_max), 64'(16'hF000));
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk) puc = 1'b0;
        drive(1,0,A_STAT,0,0,0,0,0);
        tick();
        chk("post_reset_status", 64'(data_rdata), 64'(16'h0000));

        // Randomized traffic against the model, from a fresh reset
        drive(0,0,0,0,0,0,0,0);
        puc = 1'b1;
        @(negedge clk) puc = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] lut[7];
            int idx;
            lut = '{16'hE000, 16'hE100, 16'hE200, 16'hE101, 16'hF000, 16'hF100, 16'h0000};
            data_en = ($urandom_range(0, 1) == 1);
            data_wr = ($urandom_range(0, 1) == 1);
            idx = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) data_addr = 16'h0130 + 16'($urandom_range(0, 31));
            else data_addr = 16'h0140 + 16'(idx * 2) + 16'($urandom_range(0, 1));
            if (idx == 4) data_wdata = 16'($urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) data_wdata = 16'($urandom);
            else data_wdata = lut[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
                0:       pc = mb[0];
                1:       pc = mb[1];
                default: pc = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) exec = ~exec;
            else if ($urandom_range(0, 3) == 0) exec = 1'b1;
            dma_en   = ($urandom_range(0, 23) == 0);
            dma_addr = 16'h013C + 16'($urandom_range(0, 19));
            model_eval();
            tick();
            model_commit();
            chk($sformatf("rand%0d", n),
                {data_rdata, er_min, er_max, or_min},
                {mrd, mb[0], mb[1], mb[2]});
            chk($sformatf("rand%0d_st", n),
                {or_max, locked, done, fail},
                {mb[3], mlock, mdone, mfail});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
